// File: rtl/cpu_types_pkg.sv
// Purpose: CPU-wide shared types for the memory path.
//   word_t     - 32-bit machine word
//   ramstate_t - status reported by the RAM each cycle
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Purpose: datapath-local types.
//   arb_state_t   - memory arbiter FSM state (also names the current grant)
//   is_data_grant - true when a state is one of the data-side grants
package dp_types_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IREAD  = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

  function automatic logic is_data_grant(input arb_state_t s);
    return (s == DREAD) || (s == DWRITE);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational grant selection for the memory arbiter.
//   Data requests win unless the instruction side has already lost
//   STARVE_MAX grants in a row; write wins over read when both are raised.
// Ports:
//   iREN       in  instruction read request
//   dREN       in  data read request
//   dWEN       in  data write request
//   starve_cnt in  consecutive data grants taken while iREN was pending
//   next_grant out state to enter at the next edge (IDLE = no grant)
module mem_arb_pick
  import dp_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             iREN,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [CNT_W-1:0] starve_cnt,
  output arb_state_t       next_grant
);

  logic w_force_i;

  // Grant decision: starvation override first, then data priority, then fetch.
  always_comb begin
    w_force_i  = iREN && (starve_cnt == CNT_W'(STARVE_MAX));
    next_grant = IDLE;
    if ((dREN || dWEN) && !w_force_i) begin
      next_grant = dWEN ? DWRITE : DREAD;
    end else if (iREN) begin
      next_grant = IREAD;
    end else begin
      next_grant = IDLE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares the single-ported RAM between instruction fetch and the
//   MEM-stage data path. One grant is latched per transaction and the RAM
//   controls stay stable until the RAM answers ACCESS. An IDLE cycle always
//   separates two transactions.
// Ports:
//   CLK, nRST                  clock (rising edge), async active-low reset
//   iREN, iaddr                instruction read request / address
//   dREN, dWEN, daddr, dstore  data read/write request, address, write value
//   iwait, dwait               1 while the corresponding request is not done
//   iload, dload               read data, valid in the cycle the wait drops
//   ramREN, ramWEN             RAM enables
//   ramaddr, ramstore          RAM address / write data
//   ramload, ramstate          RAM read data / RAM status (ramstate_t)
module mem_arbiter
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_SAT = CNT_W'(STARVE_MAX);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  word_t            r_addr;
  word_t            r_store;

  arb_state_t w_pick;
  ramstate_t  w_ramstate;
  logic       w_access;
  logic       w_req_held;

  assign w_ramstate = ramstate_t'(ramstate);
  assign w_access   = (w_ramstate == ACCESS);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .iREN       (iREN),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .starve_cnt (r_starve_cnt),
    .next_grant (w_pick)
  );

  // Is the requester that owns the current grant still asking? Dropping it is a flush.
  always_comb begin
    w_req_held = 1'b0;
    case (r_state)
      IREAD:   w_req_held = iREN;
      DREAD:   w_req_held = dREN;
      DWRITE:  w_req_held = dWEN;
      default: w_req_held = 1'b0;
    endcase
  end

  // Grant FSM, anti-starvation counter and per-transaction address/data latches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_addr       <= 32'h0000_0000;
      r_store      <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= w_pick;
          if (w_pick != IDLE) begin
            r_addr  <= is_data_grant(w_pick) ? daddr : iaddr;
            r_store <= dstore;
            // Only a data grant taken over a waiting fetch counts as starvation.
            if (is_data_grant(w_pick) && iREN) begin
              r_starve_cnt <= (r_starve_cnt == STARVE_SAT) ? STARVE_SAT
                                                           : r_starve_cnt + CNT_W'(1);
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        IREAD, DREAD, DWRITE: begin
          // ERROR/BUSY/FREE simply hold, so an ERROR is retried transparently.
          if (w_access || !w_req_held) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode: RAM controls from the latched grant, completion follows ACCESS directly.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'h0000_0000;
    dload    = 32'h0000_0000;
    case (r_state)
      IREAD: begin
        ramREN   = 1'b1;
        ramaddr  = r_addr;
        ramstore = r_store;
        if (w_access) begin
          iwait = 1'b0;
          iload = ramload;
        end else begin
          iwait = 1'b1;
        end
      end
      DREAD: begin
        ramREN   = 1'b1;
        ramaddr  = r_addr;
        ramstore = r_store;
        if (w_access) begin
          dwait = 1'b0;
          dload = ramload;
        end else begin
          dwait = 1'b1;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = r_addr;
        ramstore = r_store;
        if (w_access) begin
          dwait = 1'b0;
        end else begin
          dwait = 1'b1;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule
